// File: rtl/mem_cycle_ctrl_if.sv
// Z80 memory-side bus between the MMU stage and mem_cycle_ctrl.
// The master side drives the CPU strobes and translated page; the slave decodes enables and WAIT.
interface mem_cycle_ctrl_if;
    localparam int unsigned PADDR_W = 7;

    logic               mreq_n;
    logic               rd_n;
    logic               wr_n;
    logic               m1_n;
    logic               rfsh_n;
    logic [PADDR_W-1:0] paddr;
    logic               boot_clr_n;
    logic               rom_ce_n;
    logic               ram0_ce_n;
    logic               ram1_ce_n;
    logic               oe_n;
    logic               we_n;
    logic               wait_n;
    logic               boot_ovl;

    modport master (
        output mreq_n, rd_n, wr_n, m1_n, rfsh_n, paddr, boot_clr_n,
        input  rom_ce_n, ram0_ce_n, ram1_ce_n, oe_n, we_n, wait_n, boot_ovl
    );

    modport slave (
        input  mreq_n, rd_n, wr_n, m1_n, rfsh_n, paddr, boot_clr_n,
        output rom_ce_n, ram0_ce_n, ram1_ce_n, oe_n, we_n, wait_n, boot_ovl
    );
endinterface

// File: rtl/mem_cycle_ctrl.sv
// Memory cycle controller: ROM/RAM chip-enable decode, gated OE/WE, per-region WAIT insertion
// and boot ROM overlay. Define M1_WAIT_EN to add one extra wait state on opcode fetches.
module mem_cycle_ctrl #(
    parameter int unsigned WAIT_W   = 3,
    parameter int unsigned ROM_WAIT = 2,
    parameter int unsigned RAM_WAIT = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    mem_cycle_ctrl_if.slave  bus
);
    localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

    logic              act;
    logic              rom;
    logic              ram0;
    logic              ram1;
    logic              start;
    logic [WAIT_W-1:0] n_base;
    logic [WAIT_W-1:0] n_sel;
    logic [WAIT_W-1:0] count;
    logic              wait_q;
    logic              boot_ovl_q;
    logic              prev_mreq;

    // Region decode on physical address bits [19:13]; paddr[6] is A19.
    always_comb begin
        act    = !bus.mreq_n && bus.rfsh_n;
        rom    = (bus.paddr[6:3] == 4'hF) || (boot_ovl_q && (bus.paddr[6:2] == 5'b00000));
        ram0   = !bus.paddr[6] && !rom;
        ram1   = bus.paddr[6] && (bus.paddr[6:3] != 4'hF);
        start  = act && prev_mreq;
        n_base = rom ? WAIT_W'(ROM_WAIT) : WAIT_W'(RAM_WAIT);
    end

`ifdef M1_WAIT_EN
    // Opcode fetches get one extra wait state, saturating at the counter maximum.
    always_comb begin
        n_sel = n_base;
        if (!bus.m1_n && (n_base != WAIT_MAX)) begin
            n_sel = n_base + WAIT_W'(1);
        end
    end
`else
    logic unused_m1;
    assign n_sel     = n_base;
    assign unused_m1 = bus.m1_n;
`endif

    assign bus.rom_ce_n  = !(act && rom);
    assign bus.ram0_ce_n = !(act && ram0);
    assign bus.ram1_ce_n = !(act && ram1);
    assign bus.oe_n      = !(act && !bus.rd_n);
    assign bus.we_n      = !(act && !bus.wr_n);
    assign bus.wait_n    = wait_q;
    assign bus.boot_ovl  = boot_ovl_q;

    // Wait sequencing: load on cycle start, count down, release early if mreq_n goes high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_q     <= 1'b1;
            boot_ovl_q <= 1'b1;
            count      <= '0;
            prev_mreq  <= 1'b1;
        end else begin
            prev_mreq <= bus.mreq_n;
            if (!bus.boot_clr_n) begin
                boot_ovl_q <= 1'b0;
            end
            if (!wait_q) begin
                if (bus.mreq_n) begin
                    wait_q <= 1'b1;
                    count  <= '0;
                end else if (count == '0) begin
                    wait_q <= 1'b1;
                end else begin
                    count <= count - WAIT_W'(1);
                end
            end else if (start && (n_sel != '0)) begin
                wait_q <= 1'b0;
                count  <= n_sel - WAIT_W'(1);
            end
        end
    end
endmodule

// File: doc/mem_cycle_ctrl.md
Name: mem_cycle_ctrl

Overview:
- Memory-side stage directly downstream of the MMU.
- Consumes the translated physical page bits and Z80 bus strobes, and decodes the ROM/RAM chip enables.
- Generates gated OE/WE and inserts a programmable number of Z80 WAIT states per region.
- Owns the boot overlay that maps ROM into physical page 0 after reset until software clears it.

Parameters:
- WAIT_W, 3, width of wait-state counter; all wait counts are 0..2^WAIT_W-1.
- ROM_WAIT, 2, wait states inserted on ROM accesses.
- RAM_WAIT, 0, wait states inserted on RAM accesses.

Ports:
- clk  in  1  system clock (CPU clock domain).
- reset_n  in  1  synchronous active-low reset.
- mreq_n  in  1  Z80 memory request.
- rd_n  in  1  Z80 read strobe.
- wr_n  in  1  Z80 write strobe.
- m1_n  in  1  Z80 opcode fetch indicator.
- rfsh_n  in  1  Z80 refresh indicator.
- paddr  in  7  physical address bits [19:13] from MMU.
- boot_clr_n  in  1  active-low request to clear boot overlay (from I/O decode).
- rom_ce_n  out  1  ROM chip enable.
- ram0_ce_n  out  1  RAM0 chip enable (physical 0x00000-0x7FFFF).
- ram1_ce_n  out  1  RAM1 chip enable (physical 0x80000-0xEFFFF).
- oe_n  out  1  memory output enable.
- we_n  out  1  memory write enable.
- wait_n  out  1  Z80 WAIT.
- boot_ovl  out  1  overlay status, 1 = ROM overlaid at physical 0x00000-0x07FFF.

Behaviour:
- Reset (reset_n sampled low on clk rising edge): boot_ovl=1, wait_n=1, counter=0, prev_mreq=1. Reset has priority over every other event, including mid-wait; wait_n releases on that edge.
- Active access: act = !mreq_n && rfsh_n. Refresh cycles drive no chip enable and no wait.
- Region decode is combinational from paddr, boot_ovl and act:
  - rom = paddr[19:16]==4'hF, or (boot_ovl && paddr[19:15]==5'b00000).
  - ram0 = paddr[19]==0 && !rom.
  - ram1 = paddr[19]==1 && paddr[19:16]!=4'hF.
  - Each *_ce_n = !(act && region). At most one CE is low at any time; all CEs are high when mreq_n=1.
- oe_n = !(act && !rd_n); we_n = !(act && !wr_n). Both combinational; both high during refresh.
- Cycle start: detected on the clk edge where act=1 and prev_mreq=1. prev_mreq is registered mreq_n, updated every clk.
- Wait count N: ROM_WAIT for ROM, RAM_WAIT for RAM, selected by region at the start edge. Region changes after the start edge are ignored for counting.
- Wait sequencing:
  - At the start edge, if N>0: wait_n<=0, count<=N-1. If N==0, wait_n stays 1.
  - While wait_n==0: if count==0 then wait_n<=1, else count<=count-1.
  - wait_n is therefore low for exactly N consecutive clk cycles from the start edge.
  - A new start cannot occur until mreq_n returns high.
- Abort: if mreq_n is sampled high while wait_n==0, then wait_n<=1 and count<=0 on that edge.
- Boot overlay:
  - Cleared (boot_ovl<=0) on any clk edge with boot_clr_n==0.
  - Sticky 0 until reset; repeated clears have no effect.
  - Clearing during an active ROM-overlay access changes the CE decode from the next edge only. The wait count already loaded is kept.
- wait_n, boot_ovl, count and prev_mreq are the only registers. All outputs are glitch-free with respect to the registers.

Optional Feature:
- Macro: M1_WAIT_EN.
- Defined: opcode-fetch cycles (m1_n==0 at the start edge) use N+1, saturating at 2^WAIT_W-1.
- Undefined: m1_n is ignored (port retained, unused); N is as above.

Test Plan:
- Reset: reset_n=0 for 2 clk -> wait_n=1, boot_ovl=1, all CE high. Then read paddr=7'h00 with mreq_n=0, rd_n=0 -> rom_ce_n=0, oe_n=0, wait_n low exactly 2 clk (ROM_WAIT=2).
- Overlay clear: pulse boot_clr_n=0 for 1 clk -> boot_ovl=0. Read paddr=7'h00 -> ram0_ce_n=0, rom_ce_n=1, wait_n never low. Further boot_clr_n pulses leave boot_ovl=0.
- Decode sweep with mreq_n=0, wr_n=0:
  - paddr=7'h40 -> ram1_ce_n=0, we_n=0.
  - paddr=7'h78 -> rom_ce_n=0, wait_n low 2 clk.
  - paddr=7'h3F -> ram0_ce_n=0.
- Refresh: mreq_n=0, rfsh_n=0, paddr=7'h78 -> all CE high, oe_n=we_n=1, wait_n=1.
- Abort/reset mid-wait:
  - ROM cycle, raise mreq_n after 1 clk -> wait_n=1 on the next edge.
  - Repeat with reset_n=0 in wait -> wait_n=1 and boot_ovl=1 on that edge.
- M1_WAIT_EN defined, ROM_WAIT=2, m1_n=0 ROM fetch -> wait_n low 3 clk. With ROM_WAIT=7 -> low 7 clk (saturated).
